pulse_stretcher: RTL and testbench

- Converts one-clock request pulses into clean, fixed-width active-low key-style levels, for driving key_n-style inputs of downstream logic or out-of-chip lines.
- It is the opposite direction of the level-to-pulse conversion used on the key inputs of the serial-communications design: pulse in, held level out.
- Queues requests that arrive while a level is in progress and replays them with a guaranteed minimum high gap between them.

---
 rtl/pulse_stretcher.sv | 123 ++++++++++++
 tb/tb_pulse_stretcher.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Pulse-to-level stretcher: each request pulse becomes a fixed-width
// active-low level; overlapping requests are queued and replayed.
//
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous active-high reset
//   pulse_p  - request, one request per cycle sampled high
//   level_n  - stretched active-low output (registered)
//   busy     - level in progress or requests queued (registered)
//   pending  - queued requests not yet started (registered)
//   overflow - one-cycle flag when a request is dropped (registered)
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 4,
  parameter int PEND_W      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pulse_p,
  output logic              level_n,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              ovf_nxt;
  logic              pend_full;

  assign pend_full = (pending == PEND_MAX);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pending;
    ovf_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (pulse_p) begin
          state_nxt = ASSERT;
          cnt_nxt   = HOLD_LD;
        end else if (pending != '0) begin
          state_nxt = ASSERT;
          cnt_nxt   = HOLD_LD;
          pend_nxt  = pending - PEND_ONE;
        end
      end
      ASSERT: begin
        if (pulse_p) begin
          if (pend_full) ovf_nxt  = 1'b1;
          else           pend_nxt = pending + PEND_ONE;
        end
        if (cnt != CNT_ZERO) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LD;
        end
      end
      GAP: begin
        if (cnt != CNT_ZERO) begin
          cnt_nxt = cnt - CNT_ONE;
          if (pulse_p) begin
            if (pend_full) ovf_nxt  = 1'b1;
            else           pend_nxt = pending + PEND_ONE;
          end
        end else if (pulse_p) begin
          // new request starts directly: queue depth nets to zero
          state_nxt = ASSERT;
          cnt_nxt   = HOLD_LD;
        end else if (pending != '0) begin
          state_nxt = ASSERT;
          cnt_nxt   = HOLD_LD;
          pend_nxt  = pending - PEND_ONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // outputs are derived from next-state so they stay flop-driven
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= CNT_ZERO;
      pending  <= '0;
      overflow <= 1'b0;
      level_n  <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pending  <= pend_nxt;
      overflow <= ovf_nxt;
      level_n  <= (state_nxt != ASSERT);
      busy     <= (state_nxt != IDLE) || (pend_nxt != '0);
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: default parameters on one
// instance, HOLD_CYCLES=1/GAP_CYCLES=1 corner on a second.
module tb_pulse_stretcher;

  logic       clock = 1'b0;
  logic       reset;
  logic       pulse_p;
  logic       level_n;
  logic       busy;
  logic [2:0] pending;
  logic       overflow;

  logic       reset2;
  logic       pulse2;
  logic       level2;
  logic       busy2;
  logic [2:0] pending2;
  logic       overflow2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pulse_stretcher dut (
    .clock    (clock),
    .reset    (reset),
    .pulse_p  (pulse_p),
    .level_n  (level_n),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  pulse_stretcher #(
    .HOLD_CYCLES (1),
    .GAP_CYCLES  (1),
    .CNT_W       (4),
    .PEND_W      (3)
  ) dut2 (
    .clock    (clock),
    .reset    (reset2),
    .pulse_p  (pulse2),
    .level_n  (level2),
    .busy     (busy2),
    .pending  (pending2),
    .overflow (overflow2)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int e,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge %0d got %0d expected %0d",
             tag, e, got, exp);
    end
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    pulse_p = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int falls;
    int lows;
    logic prev;
    logic [7:0] exp_p;

    reset2 = 1'b1;
    pulse2 = 1'b0;
    do_reset();
    reset2 = 1'b0;

    chk("rst_level", 0, {7'd0, level_n}, 8'd1);
    chk("rst_busy", 0, {7'd0, busy}, 8'd0);
    chk("rst_pend", 0, {5'd0, pending}, 8'd0);
    chk("rst_ovf", 0, {7'd0, overflow}, 8'd0);

    // single pulse
    for (int e = 0; e <= 13; e++) begin
      pulse_p = (e == 0);
      tick();
      chk("t1_level", e, {7'd0, level_n}, (e < 8) ? 8'd0 : 8'd1);
      chk("t1_busy", e, {7'd0, busy}, (e < 12) ? 8'd1 : 8'd0);
      chk("t1_pend", e, {5'd0, pending}, 8'd0);
    end

    // three pulses back to back
    do_reset();
    for (int e = 0; e <= 40; e++) begin
      pulse_p = (e < 3);
      tick();
      if (e == 1)      exp_p = 8'd1;
      else if (e == 0) exp_p = 8'd0;
      else if (e < 12) exp_p = 8'd2;
      else if (e < 24) exp_p = 8'd1;
      else             exp_p = 8'd0;
      chk("t2_level", e, {7'd0, level_n},
          ((e % 12) < 8 && e < 36) ? 8'd0 : 8'd1);
      chk("t2_busy", e, {7'd0, busy}, (e < 36) ? 8'd1 : 8'd0);
      chk("t2_pend", e, {5'd0, pending}, exp_p);
    end

    // held high nine cycles: saturation and overflow
    do_reset();
    falls = 0;
    lows  = 0;
    prev  = 1'b1;
    for (int e = 0; e < 120; e++) begin
      pulse_p = (e < 9);
      tick();
      if (e >= 1 && e <= 7)
        chk("t3_pend", e, {5'd0, pending}, 8'(e));
      if (e == 7)
        chk("t3_ovf_pre", e, {7'd0, overflow}, 8'd0);
      if (e == 8) begin
        chk("t3_pend_sat", e, {5'd0, pending}, 8'd7);
        chk("t3_ovf", e, {7'd0, overflow}, 8'd1);
      end
      if (e == 9)
        chk("t3_ovf_post", e, {7'd0, overflow}, 8'd0);
      if (prev && !level_n) falls++;
      if (!level_n) lows++;
      prev = level_n;
    end
    chk("t3_intervals", 120, 8'(falls), 8'd8);
    chk("t3_low_cycles", 120, 8'(lows), 8'd64);
    chk("t3_busy_end", 120, {7'd0, busy}, 8'd0);

    // reset mid-ASSERT with two queued
    do_reset();
    for (int e = 0; e <= 4; e++) begin
      pulse_p = (e < 3) || (e == 4);
      reset   = (e == 4);
      tick();
      if (e == 2)
        chk("t4_pend", e, {5'd0, pending}, 8'd2);
    end
    chk("t4_level", 4, {7'd0, level_n}, 8'd1);
    chk("t4_pend_clr", 4, {5'd0, pending}, 8'd0);
    chk("t4_busy", 4, {7'd0, busy}, 8'd0);
    chk("t4_ovf", 4, {7'd0, overflow}, 8'd0);
    reset   = 1'b0;
    pulse_p = 1'b0;
    lows    = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (!level_n) lows++;
    end
    chk("t4_no_low", 24, 8'(lows), 8'd0);

    // request on the last GAP cycle
    do_reset();
    for (int e = 0; e <= 13; e++) begin
      pulse_p = (e == 0) || (e == 12);
      tick();
      chk("t5_level", e, {7'd0, level_n},
          (e >= 8 && e <= 11) ? 8'd1 : 8'd0);
      chk("t5_busy", e, {7'd0, busy}, 8'd1);
      chk("t5_pend", e, {5'd0, pending}, 8'd0);
    end
    do_reset();

    // HOLD=1 GAP=1 corner, continuous requests
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    pulse2 = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      tick();
      chk("t6_level", e, {7'd0, level2},
          (e % 2 == 0) ? 8'd0 : 8'd1);
      chk("t6_pend", e, {5'd0, pending2},
          ((e + 1) / 2 > 7) ? 8'd7 : 8'((e + 1) / 2));
      chk("t6_ovf", e, {7'd0, overflow2},
          (e % 2 == 1 && e >= 15) ? 8'd1 : 8'd0);
    end
    pulse2 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
